au_addsub_seq: RTL

Parametrised multi-cycle add/subtract unit for the arithmetic unit (AU), successor to the fixed 4-bit ripple-carry adder. Operands are W bits wide and are processed CHUNK bits per clock, least-significant chunk first, with the carry registered between chunks. A start/busy/done handshake controls each operation. Status flags are produced at completion: carry, signed overflow, zero and negative.

---
 rtl/au_addsub_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/au_addsub_seq.sv
`default_nettype none
// ============================================================================
// au_addsub_seq : multi-cycle W-bit add/subtract, CHUNK bits per clock,
//                 start/busy/done handshake, carry/ovf/zero/neg flags.
// Optional build macro: AU_SATURATE_EN (saturate S on signed overflow).
// Rev 1.0
// ============================================================================
module au_addsub_seq #(
    parameter int W     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] S,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int NCH = W / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);
    localparam logic [W-1:0]  MAX_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    generate
        if ((CHUNK < 1) || ((W % CHUNK) != 0)) begin : g_bad_width
            $error("au_addsub_seq: W must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;      // already inverted for subtract
    logic [W-1:0]    sum_sh;
    logic            carry;
    logic [IW-1:0]   idx;

    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK:0]   chunk_sum;
    logic [W-1:0]     result;
    logic [W-1:0]     final_s;
    logic             final_ovf;

    // result merges the chunk being summed this cycle so the last RUN edge
    // can commit the complete word without an extra cycle.
    always_comb begin
        a_k       = a_reg[idx*CHUNK +: CHUNK];
        b_k       = b_reg[idx*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry};
        result    = sum_sh;
        result[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        // same-sign operands producing an opposite-sign result
        final_ovf = (a_reg[W-1] ~^ b_reg[W-1]) & (result[W-1] ^ a_reg[W-1]);
        final_s   = result;
`ifdef AU_SATURATE_EN
        if (final_ovf) begin
            final_s = a_reg[W-1] ? MIN_NEG : MAX_POS;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            S      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= A;
                        b_reg <= op ? ~B : B;
                        carry <= op | cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_sh[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry <= chunk_sum[CHUNK];
                    idx   <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        S     <= final_s;
                        cout  <= chunk_sum[CHUNK];
                        ovf   <= final_ovf;
                        zero  <= (final_s == '0);
                        neg   <= final_s[W-1];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
